// File: rtl/ysyx_22041207_pkg.sv
// Shared types and constants for the LSU: FSM states, RV64 load/store funct3
// encodings and store byte-enable patterns.
package ysyx_22041207_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0F;
  localparam logic [7:0] WMASK_D = 8'hFF;

  // Byte enables for a store, relative to the request address.
  function automatic logic [7:0] store_wmask(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return WMASK_B;
      F3_SH:   return WMASK_H;
      F3_SW:   return WMASK_W;
      F3_SD:   return WMASK_D;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041207_load_ext.sv
// Combinational load extension: selects the low 8/16/32/64 bits of the
// returned window and sign- or zero-extends to the full data width.
module ysyx_22041207_load_ext
  import ysyx_22041207_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data_c
);

  always_comb begin
    data_c = '0;
    case (funct3)
      F3_LB:   data_c = {{(DATA_W-8){rdata[7]}}, rdata[7:0]};
      F3_LH:   data_c = {{(DATA_W-16){rdata[15]}}, rdata[15:0]};
      F3_LW:   data_c = {{(DATA_W-32){rdata[31]}}, rdata[31:0]};
      F3_LD:   data_c = rdata;
      F3_LBU:  data_c = {{(DATA_W-8){1'b0}}, rdata[7:0]};
      F3_LHU:  data_c = {{(DATA_W-16){1'b0}}, rdata[15:0]};
      F3_LWU:  data_c = {{(DATA_W-32){1'b0}}, rdata[31:0]};
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041207_lsu.sv
// Multi-cycle load/store unit: one op per handshake, a single memory request,
// bounded wait for the response, then a held result for writeback.
module ysyx_22041207_lsu
  import ysyx_22041207_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_err
);

  lsu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] ext_data_c;
  logic              accept, op_load, op_store, op_none, op_legal;
  logic              resp, timeout;

  // Store wins when both kinds are flagged.
  assign op_store = in_is_store;
  assign op_load  = in_is_load & ~in_is_store;
  assign op_none  = ~in_is_load & ~in_is_store;
  assign op_legal = op_store ? ~in_funct3[2] : (op_load & (in_funct3 != 3'b111));
  assign accept   = in_valid & in_ready;
  assign resp     = (state == S_WAIT) & mem_resp_valid;
  assign timeout  = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  ysyx_22041207_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .funct3 (funct3_q),
    .rdata  (mem_resp_rdata),
    .data_c (ext_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = op_legal ? S_REQ : S_DONE;
      S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_resp_valid || timeout) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    in_ready      = (state == S_IDLE);
    mem_req_valid = (state == S_REQ);
    out_valid     = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      is_load_q     <= 1'b0;
      funct3_q      <= '0;
      rd_q          <= '0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_data      <= '0;
      out_rd        <= '0;
      out_err       <= 1'b0;
    end else begin
      if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
      if (state == S_REQ && mem_req_ready) cnt <= '0;
      if (accept) begin
        is_load_q <= op_load;
        funct3_q  <= in_funct3;
        rd_q      <= op_store ? 5'd0 : in_rd;
        if (op_legal) begin
          mem_req_addr  <= in_addr;
          mem_req_wen   <= op_store;
          mem_req_wdata <= op_store ? in_wdata : '0;
          mem_req_wmask <= op_store ? store_wmask(in_funct3) : 8'h00;
        end else begin
          // Rejected op goes straight to DONE; an empty op is not an error.
          out_data <= '0;
          out_rd   <= op_store ? 5'd0 : in_rd;
          out_err  <= ~op_none;
        end
      end
      if (resp) begin
        out_data <= is_load_q ? ext_data_c : '0;
        out_rd   <= rd_q;
        out_err  <= 1'b0;
      end else if (state == S_WAIT && timeout) begin
        out_data <= '0;
        out_rd   <= rd_q;
        out_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Directed bench for the LSU: the bench plays the memory and writeback sides,
// queues expected results at issue and compares them when out_valid appears.
module tb_ysyx_22041207_lsu;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [63:0] out_data;
  logic [4:0]  out_rd;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  ysyx_22041207_lsu #(.DATA_W(64), .TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_load     (in_is_load),
    .in_is_store    (in_is_store),
    .in_funct3      (in_funct3),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_rd          (in_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_rd         (out_rd),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic [63:0] addr, input logic st,
                         input logic [63:0] wdata, input logic [7:0] mask);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
    chk({tag, "_req_addr"},  mem_req_addr, addr);
    chk({tag, "_req_wen"},   64'(mem_req_wen), 64'(st));
    chk({tag, "_req_wmask"}, 64'(mem_req_wmask), 64'(mask));
    if (st) chk({tag, "_req_wdata"}, mem_req_wdata, wdata);
  endtask

  // One op end to end. dly < 0 means memory never answers.
  task automatic run_op(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] rdata, input int stall, input int dly,
                        input int hold, input logic e_req, input logic [7:0] e_mask,
                        input logic [63:0] e_data, input logic [4:0] e_rd,
                        input logic e_err, input logic chk_rd);
    exp_t e;
    sb.push_back('{data: e_data, rd: e_rd, err: e_err});
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_rd = rd;
    step();
    in_valid = 1'b0; in_addr = 64'h0; in_wdata = 64'h0; in_rd = 5'h0;
    if (e_req) begin
      chk_req(tag, addr, st, wdata, e_mask);
      for (int k = 0; k < stall; k++) begin
        step();
        chk_req({tag, "_stall"}, addr, st, wdata, e_mask);
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk({tag, "_req_dropped"}, 64'(mem_req_valid), 64'd0);
      if (dly >= 0) begin
        for (int k = 0; k < dly; k++) begin
          step();
          chk({tag, "_wait_no_out"}, 64'(out_valid), 64'd0);
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        step();
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      end else begin
        for (int k = 0; k < int'(TO) - 1; k++) step();
        chk({tag, "_pre_timeout"}, 64'(out_valid), 64'd0);
        step();
      end
    end else begin
      chk({tag, "_no_req"}, 64'(mem_req_valid), 64'd0);
    end
    e = sb.pop_front();
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_out_data"}, out_data, e.data);
    chk({tag, "_out_err"}, 64'(out_err), 64'(e.err));
    if (chk_rd) chk({tag, "_out_rd"}, 64'(out_rd), 64'(e.rd));
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_data"}, out_data, e.data);
      chk({tag, "_hold_no_req"}, 64'(mem_req_valid), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_out_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_back_idle"}, 64'(in_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_req_wen"},   64'(mem_req_wen), 64'd0);
    chk({tag, "_req_addr"},  mem_req_addr, 64'd0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
    chk({tag, "_req_wmask"}, 64'(mem_req_wmask), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  out_data, 64'd0);
    chk({tag, "_out_rd"},    64'(out_rd), 64'd0);
    chk({tag, "_out_err"},   64'(out_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = 3'b0; in_addr = 64'h0; in_wdata = 64'h0; in_rd = 5'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
    out_ready = 1'b0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF;
    step();
    mem_resp_valid = 1'b0;
    chk_reset_outputs("idle_stray_resp");

    run_op("lb",  1, 0, 3'b000, 64'h8000_0003, 64'h0, 5'd5, 64'h1234_5678_0000_0080,
           0, 0, 0, 1, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 5'd5, 0, 1);
    run_op("lwu", 1, 0, 3'b110, 64'h8000_0010, 64'h0, 5'd7, 64'h1234_5678_9ABC_DEF0,
           3, 0, 0, 1, 8'h00, 64'h0000_0000_9ABC_DEF0, 5'd7, 0, 1);
    run_op("sh",  0, 1, 3'b001, 64'h8000_0101, 64'hAAAA_BBBB_CCCC_DDDD, 5'd9, 64'h5555,
           0, 1, 0, 1, 8'h03, 64'h0, 5'd0, 0, 1);
    run_op("ld",  1, 0, 3'b011, 64'h8000_0207, 64'h0, 5'd31, 64'hDEAD_BEEF_0123_4567,
           0, 2, 0, 1, 8'h00, 64'hDEAD_BEEF_0123_4567, 5'd31, 0, 1);
    run_op("lh",  1, 0, 3'b001, 64'h8000_0301, 64'h0, 5'd1, 64'h7777_0000_0000_8001,
           0, 0, 0, 1, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 5'd1, 0, 1);
    run_op("lhu", 1, 0, 3'b101, 64'h8000_0302, 64'h0, 5'd2, 64'hFFFF_FFFF_FFFF_8001,
           0, 0, 0, 1, 8'h00, 64'h0000_0000_0000_8001, 5'd2, 0, 1);
    run_op("lw",  1, 0, 3'b010, 64'h8000_0305, 64'h0, 5'd3, 64'hFFFF_FFFF_7FFF_FFFF,
           1, 0, 0, 1, 8'h00, 64'h0000_0000_7FFF_FFFF, 5'd3, 0, 1);
    run_op("lbu", 1, 0, 3'b100, 64'h8000_0306, 64'h0, 5'd4, 64'h0123_4567_89AB_CDFF,
           0, 0, 0, 1, 8'h00, 64'h0000_0000_0000_00FF, 5'd4, 0, 1);
    run_op("sb",  0, 1, 3'b000, 64'h8000_0400, 64'h1111_2222_3333_4444, 5'd6, 64'h0,
           0, 0, 0, 1, 8'h01, 64'h0, 5'd0, 0, 1);
    run_op("sw",  0, 1, 3'b010, 64'h8000_0402, 64'h0F0F_0F0F_F0F0_F0F0, 5'd8, 64'h0,
           2, 0, 0, 1, 8'h0F, 64'h0, 5'd0, 0, 1);
    run_op("sd",  0, 1, 3'b011, 64'h8000_0405, 64'h0123_4567_89AB_CDEF, 5'd10, 64'h0,
           0, 0, 0, 1, 8'hFF, 64'h0, 5'd0, 0, 1);
    run_op("ld_f3_111", 1, 0, 3'b111, 64'h8000_0500, 64'h0, 5'd11, 64'h0,
           0, 0, 0, 0, 8'h00, 64'h0, 5'd0, 1, 0);
    run_op("st_f3_100", 0, 1, 3'b100, 64'h8000_0500, 64'h1234, 5'd12, 64'h0,
           0, 0, 0, 0, 8'h00, 64'h0, 5'd0, 1, 1);
    run_op("neither", 0, 0, 3'b000, 64'h8000_0600, 64'h0, 5'd13, 64'h0,
           0, 0, 0, 0, 8'h00, 64'h0, 5'd0, 0, 0);
    run_op("both_sd", 1, 1, 3'b011, 64'h8000_0700, 64'hCAFE_F00D_1234_5678, 5'd14, 64'hFF,
           0, 0, 0, 1, 8'hFF, 64'h0, 5'd0, 0, 1);
    run_op("both_bad", 1, 1, 3'b101, 64'h8000_0700, 64'h0, 5'd15, 64'h0,
           0, 0, 0, 0, 8'h00, 64'h0, 5'd0, 1, 1);
    run_op("timeout", 1, 0, 3'b000, 64'h8000_0800, 64'h0, 5'd16, 64'h0,
           0, -1, 0, 1, 8'h00, 64'h0, 5'd0, 1, 0);
    run_op("resp_cyc8", 1, 0, 3'b010, 64'h8000_0804, 64'h0, 5'd17, 64'h0000_0000_8000_0000,
           0, int'(TO) - 1, 0, 1, 8'h00, 64'hFFFF_FFFF_8000_0000, 5'd17, 0, 1);
    run_op("hold5", 1, 0, 3'b000, 64'h8000_0900, 64'h0, 5'd18, 64'h0000_0000_0000_007F,
           0, 0, 5, 1, 8'h00, 64'h0000_0000_0000_007F, 5'd18, 0, 1);

    // Reset in the middle of WAIT, then a stray response that must be ignored.
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b011;
    in_addr = 64'h8000_0A00; in_rd = 5'd19;
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_wait");
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    mem_resp_valid = 1'b0;
    chk_reset_outputs("rst_stray");
    step();
    chk({"rst_stray2", "_out_valid"}, 64'(out_valid), 64'd0);

    run_op("post_rst", 1, 0, 3'b001, 64'h8000_0B00, 64'h0, 5'd20, 64'h0000_0000_0000_1234,
           0, 0, 0, 1, 8'h00, 64'h0000_0000_0000_1234, 5'd20, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
